// File: rtl/dff_pkg.sv
// dff_pkg -- shared constants for the 4-bit register built from single-bit dff
// instances.
// Contents:
//   REG_WIDTH  : bit count of the composed register
//   reg_word_t : one register word
//   REG_RESET  : value each bit of the composed register takes during reset
// The dff flop itself is self-contained and does not import this package.
package dff_pkg;

  localparam int REG_WIDTH = 4;

  typedef logic [REG_WIDTH-1:0] reg_word_t;

  localparam reg_word_t REG_RESET = '0;

endpackage : dff_pkg

// File: rtl/dff_if.sv
// dff_if -- data bus of the 4-bit register.
// Signals:
//   d : data to capture (driven by master)
//   q : registered data (driven by slave)
// Modports:
//   master : drives d, observes q
//   slave  : observes d, drives q
interface dff_if;
  import dff_pkg::*;

  reg_word_t d;
  reg_word_t q;

  modport master (output d, input q);
  modport slave  (input d, output q);

endinterface : dff_if

// File: rtl/dff_reg4.sv
// dff_reg4 -- 4-bit register composed of four single-bit dff instances.
// Ports:
//   clk : capture clock, rising-edge active
//   rst : asynchronous reset, active-high
//   bus : dff_if slave; d is captured, q is the registered value
module dff_reg4 (
  input  logic  clk,
  input  logic  rst,
  dff_if.slave  bus
);
  import dff_pkg::*;

  reg_word_t q_bits;

  for (genvar gi = 0; gi < REG_WIDTH; gi++) begin : g_bit
    dff #(
      .WIDTH       (1),
      .RESET_VALUE (REG_RESET[gi])
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .D   (bus.d[gi]),
      .Q   (q_bits[gi])
    );
  end

  assign bus.q = q_bits;

endmodule : dff_reg4

// File: rtl/dff.sv
// dff -- parameterised D flip-flop with asynchronous active-high reset.
// Parameters:
//   WIDTH       : bit width of D and Q (>= 1)
//   RESET_VALUE : value Q takes while rst is high (must fit in WIDTH bits)
// Ports:
//   clk : capture clock, rising-edge active
//   rst : asynchronous reset, active-high
//   D   : data to capture
//   Q   : registered data, driven directly by the flops
module dff #(
  parameter int WIDTH       = 1,
  parameter     RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // RESET_VALUE is left untyped so an oversized override can be detected
  // below instead of being silently truncated.
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

  if (WIDTH < 1) begin : g_bad_width
    $error("dff: WIDTH must be at least 1");
  end

  if ((RESET_VALUE >> WIDTH) != '0) begin : g_bad_reset
    $error("dff: RESET_VALUE does not fit in WIDTH bits");
  end

  // One block covers every bit; each Q bit sees only its own D bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q <= RST_Q;
    end else begin
      Q <= D;
    end
  end

endmodule : dff

// File: tb/tb_dff.sv
// tb_dff -- self-checking bench for dff (WIDTH=1 and WIDTH=8/RESET_VALUE=A5)
// and for the 4-bit register built from four single-bit dff instances.
module tb_dff;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d1  = 1'b0;
  logic       q1;
  logic [7:0] d8  = 8'h00;
  logic [7:0] q8;
  logic [3:0] d4  = 4'h0;

  // Reference model: what each Q should currently show.
  logic       e1;
  logic [7:0] e8;
  logic [3:0] e4;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  localparam logic [7:0] RV8 = 8'hA5;

  always #5 clk = ~clk;

  dff_if bus4 ();
  assign bus4.d = d4;

  dff #(.WIDTH(1)) u_dff1 (
    .clk (clk),
    .rst (rst),
    .D   (d1),
    .Q   (q1)
  );

  dff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dff8 (
    .clk (clk),
    .rst (rst),
    .D   (d8),
    .Q   (q8)
  );

  dff_reg4 u_reg4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_w1"}, {7'b0, q1}, {7'b0, e1});
    check({tag, "_w8"}, q8, e8);
    check({tag, "_r4"}, {4'b0, bus4.q}, {4'b0, e4});
  endtask

  task automatic model_reset();
    e1 = 1'b0;
    e8 = RV8;
    e4 = 4'h0;
  endtask

  // One rising edge: the model takes the reset value or the driven D.
  task automatic apply_edge(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      e1 = d1;
      e8 = d8;
      e4 = d4;
    end
    #1;
    txn++;
    $display("txn %0d %s rst=%b d1=%b d8=%h d4=%h -> q1=%b q8=%h q4=%h",
             txn, tag, rst, d1, d8, d4, q1, q8, bus4.q);
    check_all(tag);
  endtask

  logic [3:0] pat4 [6];

  initial begin
    pat4[0] = 4'b1010; pat4[1] = 4'b0101; pat4[2] = 4'b1111;
    pat4[3] = 4'b0000; pat4[4] = 4'b1001; pat4[5] = 4'b0110;

    // Reset arrives before any clock edge and must act on its own.
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("reset_async_init");

    // Reset dominance: D toggles across three edges, Q stays at reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d1 = (i == 1) ? 1'b0 : 1'b1;
      d8 = 8'($urandom);
      d4 = 4'($urandom);
      apply_edge("reset_hold");
    end

    // Release 3 units after an edge; Q waits for the next edge.
    #2 rst = 1'b0;
    d1 = 1'b1;
    d8 = 8'h3C;
    d4 = 4'hF;
    #1 check_all("release_wait");
    apply_edge("release_capture");

    // Directed 4-bit sequence.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d4 = pat4[i];
      d1 = pat4[i][0];
      d8 = {pat4[i], ~pat4[i]};
      apply_edge("seq4");
    end

    // Async reset while Q holds 1, asserted mid low phase.
    @(negedge clk);
    d1 = 1'b1;
    d8 = 8'h5A;
    d4 = 4'hF;
    apply_edge("preload");
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("reset_async_mid");
    apply_edge("reset_edge");
    #2 rst = 1'b0;

    // Randomised traffic with glitches between edges and occasional resets.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1 check_all("hold_negedge");
      d1 = 1'($urandom);
      d8 = 8'($urandom);
      d4 = 4'($urandom);
      if ($urandom_range(7) == 0) begin
        #1 rst = 1'b1;
        model_reset();
        #1 check_all("reset_async_rand");
      end
      apply_edge("rand");
      if (rst) begin
        #2 rst = 1'b0;
      end
      d1 = 1'($urandom);
      d8 = 8'($urandom);
      d4 = 4'($urandom);
      #1;
      d1 = ~d1;
      d8 = ~d8;
      d4 = ~d4;
    end
    @(negedge clk);
    #1 check_all("hold_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule : tb_dff
